// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS main control unit.
// Holds the FSM state encoding, the opcodes the controller recognises,
// and the ALUOp / ALUSrcB / PCSource select codes that the datapath
// muxes decode. The datapath imports the same package so both sides
// always agree on select encodings.
package multicycle_control_pkg;

    localparam int OP_W = 6;
    localparam int ST_W = 4;

    // Controller states; the numeric values are visible on the debug port.
    typedef enum logic [ST_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_t;

    // Instruction opcodes (instruction bits 31:26).
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // ALU operation requests.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] ALUSRCB_REGB     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR     = 2'b01;
    localparam logic [1:0] ALUSRCB_SEXT     = 2'b10;
    localparam logic [1:0] ALUSRCB_SEXT_SH2 = 2'b11;

    // PC source select.
    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

    // True for every opcode DECODE knows how to dispatch.
    function automatic logic is_supported(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_J)  || (op == OP_BEQ) ||
               (op == OP_ADDI)  || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state-to-control decoder for the multicycle control FSM.
// Ports:
//   state      in   current FSM state
//   opcode     in   instruction opcode, only used to flag illegal opcodes in DECODE
//   mem_ready  in   memory handshake, qualifies IRWrite/PCWrite in FETCH
//   remaining  out  datapath mux selects, write enables and illegal_op pulse
// Outputs are a pure function of the state except for the FETCH handshake
// qualifiers and the DECODE illegal-opcode flag.
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  logic [ST_W-1:0] state,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic            illegal_op
);

    // Every control defaults to 0; each state raises only what it needs.
    // Unused encodings fall through to the all-zero default.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUSRCB_REGB;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALURESULT;
        illegal_op    = 1'b0;
        case (state)
            S_FETCH: begin
                // PC+4 and the instruction latch commit only once memory delivers.
                mem_read  = 1'b1;
                alu_src_b = ALUSRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut speculatively.
                alu_src_b  = ALUSRCB_SEXT_SH2;
                illegal_op = ~is_supported(opcode);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_SEXT;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_SEXT;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   opcode       instruction bits 31:26, sampled in DECODE and MEMADR
//   mem_ready    memory completed the current access this cycle
//   PCWrite..PCSource  datapath mux selects and write enables
//   state        current FSM state for debug
//   illegal_op   pulse while DECODE holds an unsupported opcode
// The state register and next-state logic live here; the output decode
// is in multicycle_control_decode. All outputs are forced low while
// reset is high so an aborted instruction can never leave a strobe on.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic [ST_W-1:0] state,
    output logic            illegal_op
);

    state_t state_q;
    state_t next_state;

    logic       dec_pc_write;
    logic       dec_pc_write_cond;
    logic       dec_iord;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_ir_write;
    logic       dec_mem_to_reg;
    logic       dec_reg_dst;
    logic       dec_reg_write;
    logic       dec_alu_src_a;
    logic [1:0] dec_alu_src_b;
    logic [1:0] dec_alu_op;
    logic [1:0] dec_pc_source;
    logic       dec_illegal_op;

    // Next-state selection; memory states hold until the handshake completes
    // and unknown encodings recover to FETCH.
    always_comb begin
        next_state = S_FETCH;
        case (state_q)
            S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDI_EX;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   next_state = S_FETCH;
            S_MEMWR:   next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    next_state = S_ALUWB;
            S_ALUWB:   next_state = S_FETCH;
            S_BRANCH:  next_state = S_FETCH;
            S_JUMP:    next_state = S_FETCH;
            S_ADDI_EX: next_state = S_ADDI_WB;
            S_ADDI_WB: next_state = S_FETCH;
            default:   next_state = S_FETCH;
        endcase
    end

    // State register with asynchronous return to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= next_state;
        end
    end

    multicycle_control_decode u_decode (
        .state         (state_q),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (dec_pc_write),
        .pc_write_cond (dec_pc_write_cond),
        .iord          (dec_iord),
        .mem_read      (dec_mem_read),
        .mem_write     (dec_mem_write),
        .ir_write      (dec_ir_write),
        .mem_to_reg    (dec_mem_to_reg),
        .reg_dst       (dec_reg_dst),
        .reg_write     (dec_reg_write),
        .alu_src_a     (dec_alu_src_a),
        .alu_src_b     (dec_alu_src_b),
        .alu_op        (dec_alu_op),
        .pc_source     (dec_pc_source),
        .illegal_op    (dec_illegal_op)
    );

    // Reset masks the decoder so the datapath sees an idle controller
    // the instant reset rises, not at the next clock edge.
    assign PCWrite     = dec_pc_write      & ~reset;
    assign PCWriteCond = dec_pc_write_cond & ~reset;
    assign IorD        = dec_iord          & ~reset;
    assign MemRead     = dec_mem_read      & ~reset;
    assign MemWrite    = dec_mem_write     & ~reset;
    assign IRWrite     = dec_ir_write      & ~reset;
    assign MemtoReg    = dec_mem_to_reg    & ~reset;
    assign RegDst      = dec_reg_dst       & ~reset;
    assign RegWrite    = dec_reg_write     & ~reset;
    assign ALUSrcA     = dec_alu_src_a     & ~reset;
    assign ALUSrcB     = dec_alu_src_b     & {2{~reset}};
    assign ALUOp       = dec_alu_op        & {2{~reset}};
    assign PCSource    = dec_pc_source     & {2{~reset}};
    assign illegal_op  = dec_illegal_op    & ~reset;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A behavioural model tracks
// each instruction as a queue of remaining steps chosen at DECODE, and a
// per-step control table gives the expected outputs.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       illegal_op;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    ctrl_t obs;
    ctrl_t exp_c;
    int    exp_state;
    int    steps[$];
    int    checks = 0;
    int    errors = 0;
    int    ill_seen;
    int    mw_seen;
    int    rw_seen;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .state       (state),
        .illegal_op  (illegal_op)
    );

    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                  PCSource, illegal_op};

    always #5 clk = ~clk;

    // Expected controls for one instruction step.
    function automatic ctrl_t modelCtrl(input int st, input logic rdy, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            1:  begin c.alu_src_b = 2'b11;
                      c.illegal = !(op inside {LW, SW, RT, BEQ, JMP, ADDI}); end
            2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3:  begin c.mem_read = 1; c.iord = 1; end
            4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            5:  begin c.mem_write = 1; c.iord = 1; end
            6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            7:  begin c.reg_write = 1; c.reg_dst = 1; end
            8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
            10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            11: begin c.reg_write = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Compare state, full control word and invariants against the model.
    task automatic checkOutput(input string tag);
        exp_c = reset ? ctrl_t'(0) : modelCtrl(exp_state, mem_ready, opcode);
        checks++;
        assert (state === exp_state[3:0]) else begin
            errors++;
            $display("[TB] FAIL %s_state observed=%0d expected=%0d", tag, state, exp_state);
            $error("[TB] %s state", tag);
        end
        checks++;
        assert (obs === exp_c) else begin
            errors++;
            $display("[TB] FAIL %s_ctrl observed=%h expected=%h (state %0d)", tag, obs, exp_c, exp_state);
            $error("[TB] %s ctrl", tag);
        end
        checks++;
        assert ({MemRead, MemWrite} !== 2'b11 && {PCWrite, PCWriteCond} !== 2'b11 &&
                !(IRWrite === 1'b1 && state !== 4'd0)) else begin
            errors++;
            $display("[TB] FAIL %s_invariant observed=%h expected=exclusive strobes", tag, obs);
            $error("[TB] %s invariant", tag);
        end
    endtask

    // Advance the instruction-level model by one clock edge.
    task automatic advanceModel();
        if (exp_state == 0) begin
            exp_state = mem_ready ? 1 : 0;
        end else if ((exp_state == 3 || exp_state == 5) && !mem_ready) begin
            exp_state = exp_state;
        end else begin
            if (exp_state == 1) begin
                steps.delete();
                case (opcode)
                    LW:   steps = {2, 3, 4};
                    SW:   steps = {2, 5};
                    RT:   steps = {6, 7};
                    BEQ:  steps = {8};
                    JMP:  steps = {9};
                    ADDI: steps = {10, 11};
                    default: steps.delete();
                endcase
            end
            exp_state = (steps.size() > 0) ? steps.pop_front() : 0;
        end
    endtask

    // One clock: drive, check at negedge, step model, land just after posedge.
    task automatic applyStimulus(input logic [5:0] op, input logic rdy, input string tag);
        opcode    = op;
        mem_ready = rdy;
        @(negedge clk);
        checkOutput(tag);
        if (illegal_op === 1'b1) ill_seen++;
        if (MemWrite === 1'b1) mw_seen++;
        if (RegWrite === 1'b1) rw_seen++;
        advanceModel();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction without wait states and check its cycle count.
    task automatic runInstr(input logic [5:0] op, input int exp_cycles, input string tag);
        int n;
        n = 0;
        do begin
            applyStimulus(op, 1'b1, tag);
            n++;
        end while (state !== 4'd0 && n < 20);
        checks++;
        assert (n == exp_cycles) else begin
            errors++;
            $display("[TB] FAIL %s_latency observed=%0d expected=%0d", tag, n, exp_cycles);
            $error("[TB] %s latency", tag);
        end
    endtask

    initial begin
        logic [5:0] cur_op;
        logic [5:0] drive_op;
        reset     = 1'b1;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        exp_state = 0;
        ill_seen  = 0;
        mw_seen   = 0;
        rw_seen   = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        reset = 1'b0;

        runInstr(LW,   5, "lw");
        runInstr(SW,   4, "sw");
        runInstr(RT,   4, "rtype");
        runInstr(BEQ,  3, "beq");
        runInstr(JMP,  3, "j");
        runInstr(ADDI, 4, "addi");

        // Unsupported opcode: single illegal pulse, straight back to FETCH.
        ill_seen = 0;
        rw_seen  = 0;
        mw_seen  = 0;
        runInstr(6'b111111, 2, "illegal");
        checks++;
        assert (ill_seen == 1 && rw_seen == 0 && mw_seen == 0) else begin
            errors++;
            $display("[TB] FAIL illegal_pulse observed=%0d/%0d/%0d expected=1/0/0", ill_seen, rw_seen, mw_seen);
            $error("[TB] illegal pulse");
        end

        // Store with three wait states in MEMWR.
        mw_seen = 0;
        rw_seen = 0;
        repeat (3) applyStimulus(SW, 1'b1, "sw_stall");
        for (int i = 0; i < 4; i++) applyStimulus(SW, (i == 3), "sw_stall");
        checks++;
        assert (mw_seen == 4 && rw_seen == 0 && state === 4'd0) else begin
            errors++;
            $display("[TB] FAIL sw_stall observed=mw%0d rw%0d st%0d expected=mw4 rw0 st0", mw_seen, rw_seen, state);
            $error("[TB] sw stall");
        end

        // Reset in the middle of a stalled load.
        repeat (3) applyStimulus(LW, 1'b1, "lw_abort");
        repeat (2) applyStimulus(LW, 1'b0, "lw_abort");
        reset = 1'b1;
        #1;
        exp_state = 0;
        steps.delete();
        checkOutput("rst_async");
        @(posedge clk);
        #1;
        checkOutput("rst_hold");
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_release");
        checks++;
        assert (MemRead === 1'b1 && ALUSrcB === 2'b01) else begin
            errors++;
            $display("[TB] FAIL rst_release_fetch observed=%b/%b expected=1/01", MemRead, ALUSrcB);
            $error("[TB] release fetch");
        end
        applyStimulus(LW, 1'b0, "post_rst");

        // Random instruction stream; opcode is only meaningful in DECODE/MEMADR.
        cur_op = LW;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (exp_state == 0) begin
                case ($urandom_range(0, 6))
                    0: cur_op = LW;
                    1: cur_op = SW;
                    2: cur_op = RT;
                    3: cur_op = BEQ;
                    4: cur_op = JMP;
                    5: cur_op = ADDI;
                    default: cur_op = 6'($urandom);
                endcase
            end
            drive_op = (exp_state == 1 || exp_state == 2) ? cur_op : 6'($urandom);
            applyStimulus(drive_op, ($urandom_range(0, 3) != 0), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
